imem_cache: RTL and testbench
=============================

# imem_cache

Parametrised direct-mapped instruction cache that replaces the flat combinational instruction ROM in the fetch stage of the pipelined CPU. Hits return the instruction combinationally in the same cycle, matching the old ROM timing. Misses stall fetch while a line-refill state machine reads one line word-by-word from a slow backing memory over a req/ack handshake. It adds a one-cycle flush and a saturating miss counter.

## Interface
- `LINE_WORDS`, 4: 32-bit words per line; power of 2, ≥ 2.
- `NUM_LINES`, 16: number of lines; power of 2, ≥ 2.
- Derived: OFF_W = log2(LINE_WORDS), IDX_W = log2(NUM_LINES), TAG_W = 30 − OFF_W − IDX_W.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `iaddr` in 32: fetch byte address; bits [1:0] ignored.
- `ireq` in 1: fetch request this cycle.
- `idata` out 32: instruction; valid only when `ivalid`=1.
- `ivalid` out 1: hit; `idata` is correct this cycle.
- `stall` out 1: `ireq` & !`ivalid`; fetch must hold `iaddr`.
- `flush` in 1: invalidate all lines.
- `mem_req` out 1: backing read request.
- `mem_addr` out 32: word-aligned backing address.
- `mem_ack` in 1: `mem_rdata` valid; one word is accepted per ack cycle.
- `mem_rdata` in 32: backing read data.
- `miss_count` out 16: saturating count of refills started.

## Operation
- Address split: offset = iaddr[OFF_W+1:2], index = iaddr[OFF_W+IDX_W+1:OFF_W+2], tag = iaddr[31:OFF_W+IDX_W+2].
- Storage: data array NUM_LINES×LINE_WORDS×32, tag array, and a valid bit per line. Valid bits are cleared by reset; data and tag arrays are not reset.
- States: IDLE, REFILL.
- IDLE:
  - `ivalid` = `ireq` & valid[index] & (tag match), combinational.
  - `idata` = data[index][offset], combinational.
  - `ireq` & !hit & !`flush` → latch line base (iaddr with offset and byte bits zeroed), set word counter cnt=0, clear discard flag, move to REFILL, and increment `miss_count` (saturates at 0xFFFF).
- REFILL:
  - `ivalid` = 0. `mem_req` = 1. `mem_addr` = base + cnt·4, held stable until `mem_ack`.
  - On each `mem_ack`: data[idx][cnt] ← `mem_rdata`, then cnt++.
  - On the ack with cnt = LINE_WORDS−1: write the tag. Set valid only if discard=0. Return to IDLE.
  - Changes on `iaddr`/`ireq` during REFILL are ignored; the latched line completes.
- `flush`:
  - Clears all valid bits at the clock edge.
  - In IDLE, `flush` has priority over a miss; no refill starts that cycle and `ivalid` is forced to 0 that cycle.
  - In REFILL, `flush` sets discard=1. The refill completes all words, but the line is left invalid.
- `rst`: state=IDLE, cnt=0, all valid bits=0, discard=0, `miss_count`=0. A reset during REFILL aborts the refill immediately; `mem_req` drops in the next cycle.

## Timing
- Reset values: `mem_req`=0, `ivalid`=0, `stall`=`ireq`, `miss_count`=0, `mem_addr`=0, `idata`=don't care.
- Hit latency is 0 cycles (combinational, like a ROM).
- Miss detected in cycle T:
  - `mem_req` rises in T+1.
  - With `mem_ack` held high, words are accepted in T+1 … T+LINE_WORDS.
  - IDLE resumes in T+LINE_WORDS+1, where the held fetch hits.
  - Minimum penalty is LINE_WORDS+1 stall cycles; each ack wait cycle adds one.
- `mem_ack` while `mem_req`=0 is ignored.
- `miss_count` updates at the edge ending cycle T.

## Test plan
- Reset, then `ireq`=1, `iaddr`=0x0000_0040, `mem_ack` tied 1, `mem_rdata`=addr^0xA5A5A5A5 → `mem_addr` sequence 0x40, 0x44, 0x48, 0x4C. `stall` is high for 5 cycles, then `ivalid`=1 with `idata`=0xA5A5A5E5. `miss_count`=1.
- After that refill, `iaddr` = 0x44, 0x48, 0x4C → each hits in the same cycle, no `mem_req`, `miss_count` stays 1.
- Conflict: 0x40 cached, then fetch 0x0000_0140 (same index, different tag) → refill occurs. A later fetch of 0x40 misses again; `miss_count`=3.
- Ack stretching: `mem_ack` high only every 3rd cycle → `mem_addr` holds each word until its ack. Line completes after 12 cycles, and the data is correct.
- `flush` pulsed in the 2nd REFILL cycle for 0x80 → the refill finishes 4 words, but the next fetch of 0x80 misses and refills. `flush` in IDLE on a cached line → the next fetch of that line misses.
- `rst` asserted mid-refill → `mem_req`=0 in the next cycle. A fetch of the previously cached 0x40 misses, and `miss_count` restarts at 1. Saturation check: force 0xFFFF misses → `miss_count` stays 0xFFFF.

Source files
------------

// File: rtl/imem_cache.sv
// imem_cache: direct-mapped instruction cache with same-cycle hits and req/ack line refill
// Ports: clk/rst (rising edge, sync active-high reset)
//   fetch : iaddr/ireq in; idata/ivalid/stall out (stall = ireq & !ivalid)
//   flush : invalidates every line at the clock edge
//   memory: mem_req/mem_addr out; mem_ack/mem_rdata in (one word per ack)
//   miss_count: saturating count of refills started
module imem_cache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iaddr,
    input  logic        ireq,
    output logic [31:0] idata,
    output logic        ivalid,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] miss_count
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;
    state_t state, state_nx;

    logic [OFF_W-1:0]  off, cnt;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    // Line address of the refill in progress: {tag, index}
    logic [29-OFF_W:0] base;
    logic              discard;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]  tags [NUM_LINES];
    logic [31:0]       data [NUM_LINES*LINE_WORDS];
    logic              hit, start, accept, last;
    logic              unused_bits;

    assign off         = iaddr[OFF_W+1:2];
    assign idx         = iaddr[OFF_W+IDX_W+1:OFF_W+2];
    assign tag         = iaddr[31:OFF_W+IDX_W+2];
    assign unused_bits = ^iaddr[1:0];
    assign hit         = valid[idx] && tags[idx] == tag;
    assign accept      = state == REFILL && mem_ack;
    assign last        = cnt == OFF_W'(LINE_WORDS - 1);
    assign idata       = data[{idx, off}];
    assign stall       = ireq && !ivalid;

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // flush outranks a miss in IDLE: no refill starts and the hit is suppressed
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        ivalid   = 1'b0;
        mem_req  = 1'b0;
        mem_addr = '0;
        if (state == IDLE) begin
            ivalid   = ireq && hit && !flush;
            start    = ireq && !hit && !flush;
            state_nx = start ? REFILL : IDLE;
        end else begin
            mem_req  = 1'b1;
            mem_addr = {base, cnt, 2'b00};
            state_nx = mem_ack && last ? IDLE : REFILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            discard    <= 1'b0;
            valid      <= '0;
            miss_count <= '0;
            base       <= '0;
        end else begin
            if (start) begin
                base       <= iaddr[31:OFF_W+2];
                cnt        <= '0;
                discard    <= 1'b0;
                miss_count <= miss_count + 16'(miss_count != 16'hFFFF);
            end
            if (accept) cnt <= cnt + OFF_W'(1);
            if (state == REFILL && flush) discard <= 1'b1;
            // A flush on the final ack also leaves the line invalid
            if (flush) valid <= '0;
            else if (accept && last && !discard) valid[base[IDX_W-1:0]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) data[{base[IDX_W-1:0], cnt}] <= mem_rdata;
        if (accept && last) tags[base[IDX_W-1:0]] <= base[29-OFF_W:IDX_W];
    end
endmodule

// File: tb/tb_imem_cache.sv
// tb_imem_cache: scenario tasks with a scoreboard of expected backing addresses and fetch data
module tb_imem_cache;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst, ireq, flush, mem_ack;
    logic [31:0] iaddr, idata, mem_addr, mem_rdata;
    logic        ivalid, stall, mem_req;
    logic [15:0] miss_count;
    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Backing memory model: each word holds its own address xor KEY
    assign mem_rdata = mem_addr ^ KEY;

    imem_cache dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .ireq(ireq), .idata(idata),
        .ivalid(ivalid), .stall(stall), .flush(flush), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .miss_count(miss_count)
    );

    // Holds a fetch of a until it hits. nref line refills are expected; mem_ack is
    // high every period-th refill cycle; flush pulses in refill cycle flush_at.
    task automatic run_fetch(input logic [31:0] a, input int period, input int nref,
                             input int flush_at, output int stalls);
        int k;
        logic done;
        logic [31:0] e;
        k = 0;
        done = 1'b0;
        stalls = 0;
        for (int r = 0; r < nref; r++)
            for (int w = 0; w < 4; w++) addr_q.push_back({a[31:4], 4'h0} + 32'(w * 4));
        data_q.push_back({a[31:2], 2'b00} ^ KEY);
        iaddr = a;
        ireq = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (mem_req) k++;
            flush = mem_req && k == flush_at;
            mem_ack = mem_req ? (k % period == 0) : (period == 1);
            #1;
            if (ivalid) begin
                done = 1'b1;
                e = data_q.pop_front();
                n_checks++;
                if (idata !== e) begin
                    n_fail++;
                    $display("FAIL idata @%h: got %h expected %h", a, idata, e);
                end
            end else begin
                stalls++;
                n_checks++;
                if (stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall @%h: got %b expected 1", a, stall);
                end
                if (mem_req && mem_ack) begin
                    n_checks++;
                    if (addr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL mem_addr @%h: got %h expected no request", a, mem_addr);
                    end else begin
                        e = addr_q.pop_front();
                        if (mem_addr !== e) begin
                            n_fail++;
                            $display("FAIL mem_addr @%h: got %h expected %h", a, mem_addr, e);
                        end
                    end
                end
                @(negedge clk);
            end
        end
        flush = 1'b0;
        n_checks++;
        if (!done || addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL fetch_done @%h: hit %b words left %0d expected hit 1 left 0",
                     a, done, addr_q.size());
            addr_q.delete();
            data_q.delete();
        end
        @(negedge clk);
        ireq = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ireq = 1'b1; iaddr = 32'h40; flush = 1'b0; mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks += 5;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        if (ivalid !== 1'b0) begin n_fail++; $display("FAIL rst_ivalid: got %b expected 0", ivalid); end
        if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b expected 1", stall); end
        if (miss_count !== 16'h0) begin n_fail++; $display("FAIL rst_miss_count: got %h expected 0", miss_count); end
        if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        rst = 1'b0; ireq = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_refill();
        int s;
        run_fetch(32'h40, 1, 1, 0, s);
        n_checks += 2;
        if (s != 5) begin n_fail++; $display("FAIL refill_stalls: got %0d expected 5", s); end
        if (miss_count !== 16'd1) begin n_fail++; $display("FAIL refill_miss_count: got %0d expected 1", miss_count); end
    endtask

    task automatic test_hits();
        int s;
        for (int i = 1; i < 4; i++) begin
            run_fetch(32'h40 + 32'(i * 4), 1, 0, 0, s);
            n_checks++;
            if (s != 0) begin n_fail++; $display("FAIL hit_stalls %0d: got %0d expected 0", i, s); end
        end
        n_checks++;
        if (miss_count !== 16'd1) begin n_fail++; $display("FAIL hit_miss_count: got %0d expected 1", miss_count); end
    endtask

    task automatic test_conflict();
        int s;
        run_fetch(32'h140, 1, 1, 0, s);
        n_checks += 2;
        if (s != 5) begin n_fail++; $display("FAIL conflict_stalls: got %0d expected 5", s); end
        if (miss_count !== 16'd2) begin n_fail++; $display("FAIL conflict_count: got %0d expected 2", miss_count); end
        run_fetch(32'h40, 1, 1, 0, s);
        n_checks += 2;
        if (s != 5) begin n_fail++; $display("FAIL refetch_stalls: got %0d expected 5", s); end
        if (miss_count !== 16'd3) begin n_fail++; $display("FAIL refetch_count: got %0d expected 3", miss_count); end
    endtask

    task automatic test_ack_stretch();
        int s;
        run_fetch(32'h208, 3, 1, 0, s);
        n_checks += 2;
        if (s != 13) begin n_fail++; $display("FAIL stretch_stalls: got %0d expected 13", s); end
        if (miss_count !== 16'd4) begin n_fail++; $display("FAIL stretch_count: got %0d expected 4", miss_count); end
        run_fetch(32'h20C, 1, 0, 0, s);
        n_checks++;
        if (s != 0) begin n_fail++; $display("FAIL stretch_hit: got %0d expected 0", s); end
    endtask

    task automatic test_flush();
        int s;
        // Flushed refill completes but stays invalid, so the held fetch refills again
        run_fetch(32'h80, 1, 2, 2, s);
        n_checks += 2;
        if (s != 10) begin n_fail++; $display("FAIL flush_refill_stalls: got %0d expected 10", s); end
        if (miss_count !== 16'd6) begin n_fail++; $display("FAIL flush_refill_count: got %0d expected 6", miss_count); end
        iaddr = 32'h80; ireq = 1'b1; flush = 1'b0;
        #1;
        n_checks++;
        if (ivalid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_hit: got %b expected 1", ivalid); end
        flush = 1'b1;
        #1;
        n_checks++;
        if (ivalid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ivalid: got %b expected 0", ivalid); end
        @(negedge clk);
        flush = 1'b0;
        run_fetch(32'h80, 1, 1, 0, s);
        n_checks += 2;
        if (s != 5) begin n_fail++; $display("FAIL flush_idle_stalls: got %0d expected 5", s); end
        if (miss_count !== 16'd7) begin n_fail++; $display("FAIL flush_idle_count: got %0d expected 7", miss_count); end
    endtask

    task automatic test_reset_mid_refill();
        int s;
        iaddr = 32'h300; ireq = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_req_pre: got %b expected 1", mem_req); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks += 2;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b expected 0", mem_req); end
        if (miss_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", miss_count); end
        rst = 1'b0; ireq = 1'b0;
        @(negedge clk);
        run_fetch(32'h40, 1, 1, 0, s);
        n_checks += 2;
        if (s != 5) begin n_fail++; $display("FAIL midrst_refetch_stalls: got %0d expected 5", s); end
        if (miss_count !== 16'd1) begin n_fail++; $display("FAIL midrst_restart: got %0d expected 1", miss_count); end
    endtask

    task automatic test_saturation();
        int s;
        force dut.miss_count = 16'hFFFE;
        @(negedge clk);
        release dut.miss_count;
        @(negedge clk);
        #1;
        n_checks++;
        if (miss_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h expected fffe", miss_count); end
        run_fetch(32'h400, 1, 1, 0, s);
        n_checks++;
        if (miss_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", miss_count); end
        run_fetch(32'h500, 1, 1, 0, s);
        n_checks++;
        if (miss_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", miss_count); end
    endtask

    initial begin
        test_reset();
        test_refill();
        test_hits();
        test_conflict();
        test_ack_stretch();
        test_flush();
        test_reset_mid_refill();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
